// File: rtl/gaplus_inpctl.sv
// Gaplus control input conditioning: 2-flop sync, 14-channel debounce, coin queue
// and frame-aligned fixed-length coin pulse generator driving INP0/INP1/INP2.
//
// coin FSM states:
//   state   | meaning
//   ST_IDLE | no pulse; start one on the next frame tick if coins are queued
//   ST_ON   | coin output high, counting COIN_ON_FR frames
//   ST_OFF  | coin output low gap, counting COIN_OFF_FR frames
module gaplus_inpctl #(
  parameter int DEB_CYC     = 48000,
  parameter int COIN_ON_FR  = 3,
  parameter int COIN_OFF_FR = 3
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       VBLK,
  input  logic [4:0] iINP0,
  input  logic [4:0] iINP1,
  input  logic [1:0] iSTART,
  input  logic [1:0] iCOIN,
  output logic [4:0] oINP0,
  output logic [4:0] oINP1,
  output logic [2:0] oINP2,
  output logic [2:0] oPEND
);

  localparam int          NCH    = 14;
  localparam logic [15:0] DEB_TC = 16'(DEB_CYC - 1);
  localparam logic [3:0]  ON_TC  = 4'(COIN_ON_FR);
  localparam logic [3:0]  OFF_TC = 4'(COIN_OFF_FR);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} coin_st_t;

  logic [NCH-1:0]       raw;
  logic [NCH-1:0]       sync1_q, sync2_q;
  logic                 vblk1_q, vblk2_q, vblk3_q;
  logic [NCH-1:0]       deb_q, deb_d;
  logic [NCH-1:0][15:0] cnt_q, cnt_d;
  logic [1:0]           coin_prev_q;
  logic [2:0]           pend_q, pend_d;
  logic [3:0]           pend_sum;
  logic [3:0]           frm_q, frm_d;
  coin_st_t             st_q, st_d;
  logic                 coin_q, coin_d;
  logic                 frame_tick;
  logic [1:0]           coin_rise;
  logic                 deq;

  // channel map: [4:0] P1, [9:5] P2, [11:10] start, [13:12] coin
  assign raw        = {iCOIN, iSTART, iINP1, iINP0};
  assign frame_tick = vblk2_q & ~vblk3_q;
  assign coin_rise  = deb_q[13:12] & ~coin_prev_q;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_TC) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // The frame that closes the low gap may immediately open the next pulse,
  // giving a pulse period of exactly COIN_ON_FR + COIN_OFF_FR frames.
  always_comb begin
    st_d   = st_q;
    frm_d  = frm_q;
    coin_d = coin_q;
    deq    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (frame_tick && pend_q != 3'd0) begin
          deq    = 1'b1;
          frm_d  = 4'd0;
          st_d   = ST_ON;
          coin_d = 1'b1;
        end
      end
      ST_ON: begin
        if (frame_tick) begin
          if (frm_q + 4'd1 == ON_TC) begin
            frm_d  = 4'd0;
            st_d   = ST_OFF;
            coin_d = 1'b0;
          end else begin
            frm_d = frm_q + 4'd1;
          end
        end
      end
      ST_OFF: begin
        if (frame_tick) begin
          if (frm_q + 4'd1 == OFF_TC) begin
            frm_d = 4'd0;
            if (pend_q != 3'd0) begin
              deq    = 1'b1;
              st_d   = ST_ON;
              coin_d = 1'b1;
            end else begin
              st_d = ST_IDLE;
            end
          end else begin
            frm_d = frm_q + 4'd1;
          end
        end
      end
      default: begin
        st_d   = ST_IDLE;
        frm_d  = 4'd0;
        coin_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pend_sum = {1'b0, pend_q} + {3'b000, coin_rise[0]} + {3'b000, coin_rise[1]}
               - {3'b000, deq};
    pend_d   = (pend_sum > 4'd7) ? 3'd7 : pend_sum[2:0];
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      vblk1_q     <= 1'b0;
      vblk2_q     <= 1'b0;
      vblk3_q     <= 1'b0;
      deb_q       <= '0;
      cnt_q       <= '0;
      coin_prev_q <= '0;
      pend_q      <= '0;
      frm_q       <= '0;
      st_q        <= ST_IDLE;
      coin_q      <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      vblk1_q     <= VBLK;
      vblk2_q     <= vblk1_q;
      vblk3_q     <= vblk2_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      coin_prev_q <= deb_q[13:12];
      pend_q      <= pend_d;
      frm_q       <= frm_d;
      st_q        <= st_d;
      coin_q      <= coin_d;
    end
  end

  assign oINP0 = deb_q[4:0];
  assign oINP1 = deb_q[9:5];
  assign oINP2 = {coin_q, deb_q[11:10]};
  assign oPEND = pend_q;

endmodule

// File: tb/tb_gaplus_inpctl.sv
// Scoreboard bench for gaplus_inpctl: stimulus pushes expected output snapshots
// with their cycle stamp; a negedge monitor pops one per observed output change.
module tb_gaplus_inpctl;

  logic       MCLK   = 1'b0;
  logic       RESET  = 1'b1;
  logic       VBLK   = 1'b0;
  logic [4:0] iINP0  = '0;
  logic [4:0] iINP1  = '0;
  logic [1:0] iSTART = '0;
  logic [1:0] iCOIN  = '0;
  logic [4:0] oINP0, oINP1;
  logic [2:0] oINP2, oPEND;
  logic [15:0] outs;
  logic [15:0] last = '0;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  gaplus_inpctl #(.DEB_CYC(4), .COIN_ON_FR(2), .COIN_OFF_FR(2)) dut (
    .MCLK(MCLK), .RESET(RESET), .VBLK(VBLK),
    .iINP0(iINP0), .iINP1(iINP1), .iSTART(iSTART), .iCOIN(iCOIN),
    .oINP0(oINP0), .oINP1(oINP1), .oINP2(oINP2), .oPEND(oPEND)
  );

  assign outs = {oINP0, oINP1, oINP2, oPEND};

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  // VBLK rises just after edges 100, 200, ... and stays high 20 cycles
  always @(posedge MCLK) begin
    #1;
    VBLK = (cyc >= 100) && ((cyc % 100) < 20);
  end

  function automatic logic [15:0] mk(logic [4:0] a, logic [4:0] b, logic [2:0] c,
                                     logic [2:0] p);
    return {a, b, c, p};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic push(int c, logic [15:0] v, string nm);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // leaves the caller 1 time unit after edge n
  task automatic at(int n);
    while (cyc < n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  always @(negedge MCLK) begin
    if (outs !== last) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, outs, last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_cyc"}, cyc, e.cyc);
        chk({e.name, "_val"}, {16'h0, outs}, {16'h0, e.val});
      end
      last = outs;
    end
  end

  initial begin
    at(2);
    chk("reset_state", {16'h0, outs}, 32'h0);
    at(3);
    RESET = 1'b0;

    // debounce: 3-cycle glitch rejected, held level accepted 6 edges later
    at(10); iINP0 = 5'b00001;
    at(13); iINP0 = 5'b00000;
    at(20); push(26, mk(5'b00001, 5'b0, 3'b0, 3'd0), "p1_up_on");  iINP0 = 5'b00001;
    at(30); push(36, mk(5'b0, 5'b0, 3'b0, 3'd0), "p1_up_off");     iINP0 = 5'b00000;

    // start and P2 pass-through, coin bit untouched
    at(40); push(46, mk(5'b0, 5'b0, 3'b010, 3'd0), "start2_on");   iSTART = 2'b10;
    at(50); push(56, mk(5'b0, 5'b0, 3'b000, 3'd0), "start2_off");  iSTART = 2'b00;
    at(60); push(66, mk(5'b0, 5'b10101, 3'b0, 3'd0), "p2_on");     iINP1 = 5'b10101;
    at(70); push(76, mk(5'b0, 5'b0, 3'b0, 3'd0), "p2_off");        iINP1 = 5'b00000;
    at(80); push(86, mk(5'b11010, 5'b00101, 3'b0, 3'd0), "p1p2_on");
    iINP0 = 5'b11010; iINP1 = 5'b00101;
    at(90); push(96, mk(5'b0, 5'b0, 3'b0, 3'd0), "p1p2_off");
    iINP0 = 5'b0; iINP1 = 5'b0;

    // single coin: queued at 117, pulse from tick 203 to 403
    at(110);
    push(117, mk(5'b0, 5'b0, 3'b000, 3'd1), "coin1_queued");
    push(203, mk(5'b0, 5'b0, 3'b100, 3'd0), "coin1_pulse_on");
    push(403, mk(5'b0, 5'b0, 3'b000, 3'd0), "coin1_pulse_off");
    iCOIN = 2'b01;
    at(120); iCOIN = 2'b00;

    // both coins together (+2), six more presses saturate at 7, seven pulses
    at(610);
    push(617, mk(5'b0, 5'b0, 3'b0, 3'd2), "pend2");
    push(637, mk(5'b0, 5'b0, 3'b0, 3'd3), "pend3");
    push(647, mk(5'b0, 5'b0, 3'b0, 3'd4), "pend4");
    push(657, mk(5'b0, 5'b0, 3'b0, 3'd5), "pend5");
    push(667, mk(5'b0, 5'b0, 3'b0, 3'd6), "pend6");
    push(677, mk(5'b0, 5'b0, 3'b0, 3'd7), "pend7");
    for (int i = 0; i < 7; i++) begin
      push(703 + 400 * i, mk(5'b0, 5'b0, 3'b100, 3'(6 - i)), $sformatf("burst%0d_on", i));
      push(903 + 400 * i, mk(5'b0, 5'b0, 3'b000, 3'(6 - i)), $sformatf("burst%0d_off", i));
    end
    iCOIN = 2'b11;
    at(620); iCOIN = 2'b00;
    for (int i = 0; i < 6; i++) begin
      at(630 + 10 * i);
      iCOIN = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    at(690); iCOIN = 2'b00;

    // enqueue during ON: no stretch, next pulse when the gap closes
    at(3510);
    push(3517, mk(5'b0, 5'b0, 3'b000, 3'd1), "enq_pend1");
    push(3603, mk(5'b0, 5'b0, 3'b100, 3'd0), "enq_first_on");
    push(3657, mk(5'b0, 5'b0, 3'b100, 3'd1), "enq_during_on");
    push(3803, mk(5'b0, 5'b0, 3'b000, 3'd1), "enq_first_off");
    push(4003, mk(5'b0, 5'b0, 3'b100, 3'd0), "enq_second_on");
    push(4203, mk(5'b0, 5'b0, 3'b000, 3'd0), "enq_second_off");
    iCOIN = 2'b01;
    at(3520); iCOIN = 2'b00;
    at(3650); iCOIN = 2'b01;
    at(3660); iCOIN = 2'b00;

    // reset while pulsing with three coins queued
    at(4410);
    push(4417, mk(5'b0, 5'b0, 3'b000, 3'd2), "rst_pend2");
    push(4437, mk(5'b0, 5'b0, 3'b000, 3'd3), "rst_pend3");
    push(4503, mk(5'b0, 5'b0, 3'b100, 3'd2), "rst_pulse_on");
    push(4517, mk(5'b0, 5'b0, 3'b100, 3'd3), "rst_pend3_on");
    push(4550, mk(5'b0, 5'b0, 3'b000, 3'd0), "rst_clear");
    iCOIN = 2'b11;
    at(4420); iCOIN = 2'b00;
    at(4430); iCOIN = 2'b01;
    at(4440); iCOIN = 2'b00;
    at(4510); iCOIN = 2'b01;
    at(4520); iCOIN = 2'b00;
    at(4550);
    #2 RESET = 1'b1;
    #1 chk("async_reset_outs", {16'h0, outs}, 32'h0);
    at(4560); RESET = 1'b0;
    at(5590);
    chk("post_reset_pend", {29'h0, oPEND}, 32'h0);
    chk("post_reset_coin", {31'h0, oINP2[2]}, 32'h0);

    // inputs held through reset release: joystick accepted, one coin issued
    at(5600);
    push(5616, mk(5'b10000, 5'b0, 3'b000, 3'd0), "held_trig");
    push(5617, mk(5'b10000, 5'b0, 3'b000, 3'd1), "held_coin_queued");
    push(5703, mk(5'b10000, 5'b0, 3'b100, 3'd0), "held_coin_on");
    push(5903, mk(5'b10000, 5'b0, 3'b000, 3'd0), "held_coin_off");
    push(5916, mk(5'b00000, 5'b0, 3'b000, 3'd0), "held_trig_off");
    RESET = 1'b1;
    iINP0 = 5'b10000;
    iCOIN = 2'b10;
    at(5610); RESET = 1'b0;
    at(5910); iINP0 = 5'b0; iCOIN = 2'b00;

    at(6300);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_%s at_cyc=%0d want=%h", e.name, e.cyc, e.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
